// File: rtl/tdc_frame_packer_64b.sv
// Buffers 32-bit TDC hit words and packs them two per 64-bit frame with per-byte K flags.
// Overflow is reported in-band as a K28.6 (0xDC) error slot carrying the first dropped channel.
module tdc_frame_packer_64b #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [31:0]              chnl_data_32b,
    input  logic                     chnl_data_valid,
    input  logic                     tx_ready,
    output logic [63:0]              data_64b,
    output logic [7:0]               o_Kin,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow_pending
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] IDLE_WORD = 32'hBCBC_BCBC;
    localparam logic [3:0]  K_IDLE    = 4'b1111;
    localparam logic [3:0]  K_DATA    = 4'b0000;
    localparam logic [3:0]  K_ERR     = 4'b1011;

    logic [31:0]      mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count;
    logic [AW:0]      count_after_pop;
    logic [1:0]       pop_n;
    logic             fire;
    logic             push_ok;
    logic             push;
    logic             drop;
    logic             err_load;
    logic [31:0]      head_word, second_word;
    logic [31:0]      upper_word, lower_word;
    logic [3:0]       upper_k, lower_k;
    logic [4:0]       err_chnum_reg;
    logic [63:0]      data_reg;
    logic [7:0]       kin_reg;
    logic [CNT_W-1:0] drop_count_reg;
    logic             pending_reg;

    assign count     = wr_ptr_reg - rd_ptr_reg;
    assign fire      = enable & tx_ready;
    assign err_load  = fire & pending_reg;
    assign head_word   = mem[rd_ptr_reg[AW-1:0]];
    assign second_word = mem[rd_ptr_reg[AW-1:0] + AW'(1)];

    // The error slot always takes the upper half, so at most one data word follows it.
    always_comb begin
        pop_n = 2'd0;
        if (fire) begin
            if (pending_reg) begin
                pop_n = (count != '0) ? 2'd1 : 2'd0;
            end else if (count >= (AW+1)'(2)) begin
                pop_n = 2'd2;
            end else if (count == (AW+1)'(1)) begin
                pop_n = 2'd1;
            end
        end
    end

    assign count_after_pop = count - {{(AW-1){1'b0}}, pop_n};
    assign push_ok = count_after_pop < (AW+1)'(DEPTH);
    assign push    = enable & chnl_data_valid & push_ok;
    assign drop    = enable & chnl_data_valid & ~push_ok;

    always_comb begin
        upper_word = IDLE_WORD;
        upper_k    = K_IDLE;
        lower_word = IDLE_WORD;
        lower_k    = K_IDLE;
        if (pending_reg) begin
            upper_word = {8'hDC, err_chnum_reg, 3'b000, 16'hBCBC};
            upper_k    = K_ERR;
            if (count != '0) begin
                lower_word = head_word;
                lower_k    = K_DATA;
            end
        end else if (count != '0) begin
            upper_word = head_word;
            upper_k    = K_DATA;
            if (count >= (AW+1)'(2)) begin
                lower_word = second_word;
                lower_k    = K_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= chnl_data_32b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            data_reg       <= {2{IDLE_WORD}};
            kin_reg        <= 8'hFF;
            drop_count_reg <= '0;
            pending_reg    <= 1'b0;
            err_chnum_reg  <= '0;
        end else if (enable) begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            rd_ptr_reg <= rd_ptr_reg + {{(AW-1){1'b0}}, pop_n};
            if (fire) begin
                data_reg <= {upper_word, lower_word};
                kin_reg  <= {upper_k, lower_k};
            end
            if (drop && (drop_count_reg != {CNT_W{1'b1}})) begin
                drop_count_reg <= drop_count_reg + CNT_W'(1);
            end
            // A drop coinciding with the error-slot load re-arms with the new channel.
            if (drop && (!pending_reg || err_load)) begin
                pending_reg   <= 1'b1;
                err_chnum_reg <= chnl_data_32b[31:27];
            end else if (err_load) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign data_64b         = data_reg;
    assign o_Kin            = kin_reg;
    assign fifo_count       = count;
    assign drop_count       = drop_count_reg;
    assign overflow_pending = pending_reg;

endmodule

// File: tb/tb_tdc_frame_packer_64b.sv
// Scoreboard bench for tdc_frame_packer_64b: a queue-based reference model predicts frames and status.
module tb_tdc_frame_packer_64b;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    enable = 1'b0;
    logic [31:0]             chnl_data_32b = '0;
    logic                    chnl_data_valid = 1'b0;
    logic                    tx_ready = 1'b0;
    logic [63:0]             data_64b;
    logic [7:0]              o_Kin;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [CNT_W-1:0]        drop_count;
    logic                    overflow_pending;

    tdc_frame_packer_64b #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .chnl_data_32b(chnl_data_32b), .chnl_data_valid(chnl_data_valid),
        .tx_ready(tx_ready), .data_64b(data_64b), .o_Kin(o_Kin),
        .fifo_count(fifo_count), .drop_count(drop_count),
        .overflow_pending(overflow_pending)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] d; logic [7:0] k; } frame_t;
    typedef struct { logic [63:0] d; logic [7:0] k; int cnt; int drops; bit pend; } stat_t;

    frame_t fq[$];
    stat_t  sq[$];
    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_pend = 0;
    logic [4:0]  m_errch = '0;
    int          m_drops = 0;
    logic [63:0] m_data = {2{32'hBCBC_BCBC}};
    logic [7:0]  m_k = 8'hFF;
    int          since_tx = 10;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic take_slot(output logic [31:0] w, output logic [3:0] k);
        if (mq.size() > 0) begin
            w = mq.pop_front();
            k = 4'b0000;
        end else begin
            w = 32'hBCBC_BCBC;
            k = 4'b1111;
        end
    endtask

    task automatic step(input bit r, input bit en, input bit v, input logic [31:0] w, input bit t);
        logic [31:0] uw, lw;
        logic [3:0]  uk, lk;
        stat_t s;
        @(negedge clk);
        rst = r; enable = en; chnl_data_valid = v; chnl_data_32b = w; tx_ready = t;
        if (r) begin
            mq.delete();
            m_pend = 0; m_errch = '0; m_drops = 0;
            m_data = {2{32'hBCBC_BCBC}}; m_k = 8'hFF;
        end else if (en) begin
            if (t) begin
                if (m_pend) begin
                    uw = {8'hDC, m_errch, 3'b000, 16'hBCBC};
                    uk = 4'b1011;
                    m_pend = 0;
                end else begin
                    take_slot(uw, uk);
                end
                take_slot(lw, lk);
                m_data = {uw, lw};
                m_k = {uk, lk};
                fq.push_back('{d: m_data, k: m_k});
            end
            if (v) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(w);
                end else begin
                    if (m_drops < (1 << CNT_W) - 1) m_drops++;
                    if (!m_pend) begin
                        m_pend = 1;
                        m_errch = w[31:27];
                    end
                end
            end
        end
        s.d = m_data; s.k = m_k; s.cnt = mq.size(); s.drops = m_drops; s.pend = m_pend;
        sq.push_back(s);
    endtask

    // Monitor: a frame is presented after each accepted tx_ready; status is checked every cycle.
    initial begin
        bit fire_s;
        frame_t f;
        stat_t s;
        forever begin
            @(posedge clk);
            fire_s = (rst === 1'b0) && (enable === 1'b1) && (tx_ready === 1'b1);
            #1;
            if (fire_s) begin
                if (fq.size() == 0) begin
                    chk("frame_queue_nonempty", 64'd0, 64'd1);
                end else begin
                    f = fq.pop_front();
                    chk("frame_data", data_64b, f.d);
                    chk("frame_kin", {56'd0, o_Kin}, {56'd0, f.k});
                end
            end
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("hold_data", data_64b, s.d);
                chk("hold_kin", {56'd0, o_Kin}, {56'd0, s.k});
                chk("fifo_count", 64'(fifo_count), 64'(s.cnt));
                chk("drop_count", 64'(drop_count), 64'(s.drops));
                chk("overflow_pending", 64'(overflow_pending), 64'(s.pend));
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Idle frame
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        // Single word
        step(0, 1, 1, 32'h1234_5678, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        // Three words over two frames
        step(0, 1, 1, 32'hAAAA_0001, 0);
        step(0, 1, 1, 32'hBBBB_0002, 0);
        step(0, 1, 1, 32'hCCCC_0003, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        // Overflow: fill, then three drops with first dropped channel 9
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 32'h0100_0000 + i, 0);
        step(0, 1, 1, 32'h4800_0000, 0);
        step(0, 1, 1, 32'hF800_0001, 0);
        step(0, 1, 1, 32'h1000_0002, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        // Refill to full, then push with a same-cycle pop
        step(0, 1, 1, 32'h0200_0000, 0);
        step(0, 1, 1, 32'h0300_0000, 1);
        step(0, 1, 0, 0, 0);
        // enable low: pushes and tx_ready ignored
        step(0, 0, 1, 32'h0400_0000, 1);
        step(0, 0, 1, 32'h0500_0000, 0);
        step(0, 0, 1, 32'h0600_0000, 1);
        step(0, 0, 1, 32'h0700_0000, 0);
        // Reset mid-stream discards everything
        step(1, 1, 1, 32'h0800_0000, 0);
        step(0, 1, 0, 0, 0);
        since_tx = 10;
        // Randomized traffic with phases of varying push pressure
        for (int n = 0; n < 4000; n++) begin
            bit en, v, t, r;
            int vprob;
            vprob = ((n / 500) % 2 == 0) ? 80 : 30;
            r  = ($urandom_range(0, 999) == 0);
            en = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 99) < vprob);
            t  = (since_tx >= 2) && ($urandom_range(0, 2) == 0);
            since_tx = t ? 1 : since_tx + 1;
            step(r, en, v, $urandom, t);
        end
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("frame_queue_drained", 64'(fq.size()), 64'd0);
        chk("status_queue_drained", 64'(sq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdc_frame_packer_64b.md
Name: tdc_frame_packer_64b

Overview:
- Transmit-side counterpart of the 64-bit channel-aligner. It buffers 32-bit TDC hit words (chnum[31:27], mode[26:25], leading[24:8], width[7:0]) and packs them into 64-bit frames.
- Each 64-bit frame carries two 32-bit slots: upper [63:32] and lower [31:0]. Each frame has a per-byte K-flag vector for the downstream 8b10b encoder/serializer.
- Empty slots are filled with K28.5 idles (0xBC).
- FIFO overflow is reported in-band with a triggerless error packet (K 0xDC), in the format the receive-side aligner decodes.

Parameters:
- DEPTH, 16, hit FIFO depth in 32-bit words; must be a power of 2, minimum 4.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  block enable; when 0, no push, no pop, and outputs hold
- chnl_data_32b  in  32  hit word
- chnl_data_valid  in  1  push strobe for chnl_data_32b
- tx_ready  in  1  one-cycle strobe from the serializer: current frame consumed
- data_64b  out  64  current frame; byte 7 = [63:56]
- o_Kin  out  8  K flag per byte; bit i corresponds to byte i
- fifo_count  out  $clog2(DEPTH)+1  words held in the FIFO
- drop_count  out  CNT_W  dropped hit words, saturating
- overflow_pending  out  1  an error packet is waiting to be sent

Behaviour:
- Reset:
  - data_64b = 64'hBCBC_BCBC_BCBC_BCBC and o_Kin = 8'hFF.
  - FIFO is flushed; fifo_count = 0, drop_count = 0, overflow_pending = 0.
  - A reset mid-frame discards everything; the idle frame is presented on the next cycle.
- Slot encodings (byte order high to low):
  - Idle slot: BC BC BC BC, K nibble 4'b1111.
  - Data slot: the hit word unmodified, K nibble 4'b0000.
  - Error slot: DC, {err_chnum[4:0],3'b000}, BC, BC; K nibble 4'b1011.
- Push:
  - When enable & chnl_data_valid, the word is written if the FIFO is not full after this cycle's pop.
  - A same-cycle pop frees space, so a push to a full FIFO is accepted if a pop occurs in the same cycle.
  - Otherwise the word is dropped and drop_count increments, saturating at all-ones.
  - On a drop with overflow_pending = 0: err_chnum <= dropped word[31:27] and overflow_pending <= 1.
  - On a drop with overflow_pending = 1: err_chnum is kept (first dropped channel wins).
- Frame build: on enable & tx_ready, the next frame is registered and appears on the outputs 1 cycle later (tx_ready + 1).
  - Upper slot: error slot if overflow_pending; else FIFO head if not empty; else idle.
  - Lower slot: next FIFO word if available (after any upper-slot pop); else idle.
  - An error packet never occupies the lower slot.
  - 0, 1 or 2 words are popped per frame. overflow_pending clears when the error slot is loaded.
  - A drop in the same cycle as the error slot load sets overflow_pending again with the new channel.
- Ordering: hit words leave in FIFO order; within a frame the upper slot precedes the lower slot.
- Handshake:
  - The outputs stay stable between tx_ready strobes.
  - tx_ready minimum spacing is 2 cycles; a tx_ready on consecutive cycles is outside the protocol.
  - tx_ready with enable = 0 is ignored.
- enable = 0: inputs ignored (not counted as drops), FIFO and counters frozen, frame held.
- Pointers are DEPTH-power-of-2 wrapping; fifo_count is exact from 0 to DEPTH.

Test Plan:
- Reset, then tx_ready with no data -> data_64b = BCBC_BCBC_BCBC_BCBC, o_Kin = 8'hFF; fifo_count = 0.
- Push 32'h1234_5678, then tx_ready -> next cycle data_64b = 1234_5678_BCBC_BCBC, o_Kin = 8'h0F, fifo_count = 0.
- Push A = 32'hAAAA_0001, B = 32'hBBBB_0002, C = 32'hCCCC_0003, then two tx_ready strobes 4 cycles apart:
  - frame 1 = {A,B}, o_Kin = 8'h00;
  - frame 2 = {C, BCBC_BCBC}, o_Kin = 8'h0F.
- Fill with DEPTH=16 words, push 3 more, first with chnum = 5'd9 (word 32'h4800_0000), no tx_ready:
  - drop_count = 3, overflow_pending = 1.
  - Next tx_ready -> upper slot = DC 48 BC BC, lower slot = FIFO word 0; o_Kin = 8'hB0; overflow_pending = 0.
- Full FIFO, push and tx_ready in the same cycle -> push accepted, drop_count unchanged, fifo_count = 15 (two popped, one pushed).
- enable = 0 while pushing 4 words and pulsing tx_ready -> fifo_count, drop_count and outputs unchanged.
